dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the byte-address width (256-byte data memory).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the word width.
REQ-003 The block SHALL have port i_clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst  input  1  meaning the reset, synchronous and active-high.
REQ-005 The block SHALL have ports i_req0/i_req1  input  1  meaning access request from port 0 (CPU) or port 1 (debug/dump engine).
REQ-006 The block SHALL have ports i_we0/i_we1  input  1  meaning write (1) or read (0).
REQ-007 The block SHALL have ports i_addr0/i_addr1  input  ADDR_W  meaning the byte address.
REQ-008 The block SHALL have ports i_wdata0/i_wdata1  input  DATA_W  meaning the write data.
REQ-009 The block SHALL have ports o_gnt0/o_gnt1  output  1  meaning request accepted this cycle.
REQ-010 The block SHALL have ports o_rvalid0/o_rvalid1  output  1  meaning read data valid.
REQ-011 The block SHALL have ports o_rdata0/o_rdata1  output  DATA_W  meaning the read data.
REQ-012 The block SHALL have ports o_err0/o_err1  output  1  meaning misaligned-access response.
REQ-013 The block SHALL have ports o_mem_en, o_mem_we  output  1 each, o_mem_addr  output  ADDR_W, o_mem_wdata  output  DATA_W  meaning the memory command.
REQ-014 The block SHALL have port i_mem_rdata  input  DATA_W  meaning memory read data, valid one cycle after a read command.
REQ-015 The block SHALL have port o_conflict_cnt  output  16  meaning the count of cycles with both requests asserted.

Function
REQ-016 Grant SHALL be combinational in the request cycle; at most one of o_gnt0/o_gnt1 SHALL be high per cycle.
REQ-017 With a single requester active, that requester SHALL be granted.
REQ-018 With both requesting, the port not granted on the most recent conflict SHALL win (round-robin); the last_winner register SHALL update only on conflict cycles.
REQ-019 A requester SHALL hold req, we, addr and wdata stable until granted; the arbiter SHALL NOT buffer ungranted requests.
REQ-020 An aligned grant (addr[1:0]==0) SHALL drive o_mem_en=1, o_mem_we=we, o_mem_addr=addr and o_mem_wdata=wdata in the same cycle; otherwise o_mem_en SHALL be 0.
REQ-021 An aligned granted read SHALL produce o_rvalidN=1 and o_rdataN=i_mem_rdata exactly one cycle later, for one cycle, on the granted port only.
REQ-022 An aligned write SHALL produce no response pulse.
REQ-023 A misaligned grant SHALL suppress the memory command (o_mem_en=0, no write) and pulse o_errN for one cycle, one cycle later; o_rvalidN SHALL stay 0.
REQ-024 Back-to-back grants SHALL be supported every cycle; the read pipeline (pending flag plus port ID) SHALL be one entry deep, with the response for cycle t issued at t+1 regardless of the grant at t+1.
REQ-025 o_rdataN SHALL hold its last value when o_rvalidN=0.
REQ-026 o_conflict_cnt SHALL increment on each cycle with i_req0&i_req1 and saturate at 16'hFFFF.

Reset
REQ-027 While i_rst=1, o_gnt*, o_mem_en and o_mem_we SHALL be 0.
REQ-028 On a clock edge with i_rst=1: o_rvalid*, o_err*, o_rdata* SHALL become 0, o_conflict_cnt SHALL become 0, the pending read SHALL be cleared, and last_winner SHALL become 1, so port 0 wins the first conflict.
REQ-029 A read granted in the cycle before reset asserts SHALL have its response dropped.

Structure
REQ-030 Package dmem_arb_pkg SHALL hold ADDR_W/DATA_W defaults, port-index constants PORT_CPU=0 and PORT_DBG=1, and the counter width.
REQ-031 The two-way round-robin decision and last_winner register SHALL be a sub-module rr_arb2; the datapath muxing, response pipeline and counter SHALL remain in dmem_arbiter.

Verification
REQ-032 Scenario: port0 read at addr 0x04 alone, memory returns 0xDEADBEEF -> o_gnt0 same cycle; next cycle o_rvalid0=1, o_rdata0=0xDEADBEEF; o_rvalid1=0.
REQ-033 Scenario: both ports request reads for 3 consecutive cycles after reset -> grants go 0,1,0; o_conflict_cnt=3.
REQ-034 Scenario: port1 write 0x12345678 at addr 0x10, then port0 read of 0x10 -> o_mem_we=1 with addr 0x10 on the write; the read returns 0x12345678.
REQ-035 Scenario: port0 write at addr 0x06 -> granted, o_mem_en=0, o_err0=1 the next cycle, memory unchanged.
REQ-036 Scenario: port0 read granted, then i_rst=1 the next cycle -> o_rvalid0 stays 0; after reset, a conflict is won by port 0.
REQ-037 Scenario: force the counter to 16'hFFFE and hold a conflict for 3 cycles -> o_conflict_cnt=16'hFFFF, no wrap.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the two-port data-memory arbiter.
package dmem_arb_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; last_winner only moves on conflict cycles.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_winner;
  logic conflict;
  logic winner;

  always_comb begin
    conflict = req0 & req1;
    winner   = (last_winner == PORT_DBG) ? PORT_CPU : PORT_DBG;
    gnt0     = ~rst & ((req0 & ~req1) | (conflict & (winner == PORT_CPU)));
    gnt1     = ~rst & ((req1 & ~req0) | (conflict & (winner == PORT_DBG)));
  end

  // Reset to DBG so the CPU takes the first conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner <= PORT_DBG;
    end else if (conflict) begin
      last_winner <= winner;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: combinational grant, one-deep read response
// pipeline, misaligned-access error pulses and a saturating conflict counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_err0,
  output logic              o_err1,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [CNT_W-1:0]  o_conflict_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic              gnt0;
  logic              gnt1;
  logic              any_gnt;
  logic              sel_p0;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              aligned;

  logic              rd_vld_p1;
  logic              rd_port_p1;
  logic              err0_p1;
  logic              err1_p1;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [CNT_W-1:0]  conflict_cnt_q;

  rr_arb2 u_rr (
    .clk  (i_clk),
    .rst  (i_rst),
    .req0 (i_req0),
    .req1 (i_req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // Stage p0: grant-cycle command mux
  always_comb begin
    any_gnt     = gnt0 | gnt1;
    sel_p0      = gnt1 ? PORT_DBG : PORT_CPU;
    sel_we      = gnt1 ? i_we1    : i_we0;
    sel_addr    = gnt1 ? i_addr1  : i_addr0;
    sel_wdata   = gnt1 ? i_wdata1 : i_wdata0;
    aligned     = (sel_addr[1:0] == 2'b00);
    o_gnt0      = gnt0;
    o_gnt1      = gnt1;
    o_mem_en    = any_gnt & aligned;
    o_mem_we    = any_gnt & aligned & sel_we;
    o_mem_addr  = sel_addr;
    o_mem_wdata = sel_wdata;
  end

  // Stage p1: response registers, one entry deep
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_vld_p1      <= 1'b0;
      rd_port_p1     <= PORT_CPU;
      err0_p1        <= 1'b0;
      err1_p1        <= 1'b0;
      rdata0_q       <= '0;
      rdata1_q       <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rd_vld_p1  <= any_gnt & aligned & ~sel_we;
      rd_port_p1 <= sel_p0;
      err0_p1    <= gnt0 & ~aligned;
      err1_p1    <= gnt1 & ~aligned;
      if (o_rvalid0) rdata0_q <= i_mem_rdata;
      if (o_rvalid1) rdata1_q <= i_mem_rdata;
      if (i_req0 & i_req1) conflict_cnt_q <= sat_inc(conflict_cnt_q);
    end
  end

  // Memory data lands the cycle after the command; masking with reset drops
  // a read that was granted just before reset asserted.
  always_comb begin
    o_rvalid0      = ~i_rst & rd_vld_p1 & (rd_port_p1 == PORT_CPU);
    o_rvalid1      = ~i_rst & rd_vld_p1 & (rd_port_p1 == PORT_DBG);
    o_rdata0       = o_rvalid0 ? i_mem_rdata : rdata0_q;
    o_rdata1       = o_rvalid1 ? i_mem_rdata : rdata1_q;
    o_err0         = ~i_rst & err0_p1;
    o_err1         = ~i_rst & err1_p1;
    o_conflict_cnt = conflict_cnt_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural word memory.
module tb_dmem_arbiter;

  logic        tb_i_clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [15:0] conflict_cnt;

  logic [31:0] mem [64];

  int vectors = 0;
  int miscompares = 0;

  always #5 tb_i_clk = ~tb_i_clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .i_clk          (tb_i_clk),
    .i_rst          (rst),
    .i_req0         (req0),
    .i_req1         (req1),
    .i_we0          (we0),
    .i_we1          (we1),
    .i_addr0        (addr0),
    .i_addr1        (addr1),
    .i_wdata0       (wdata0),
    .i_wdata1       (wdata1),
    .o_gnt0         (gnt0),
    .o_gnt1         (gnt1),
    .o_rvalid0      (rvalid0),
    .o_rvalid1      (rvalid1),
    .o_rdata0       (rdata0),
    .o_rdata1       (rdata1),
    .o_err0         (err0),
    .o_err1         (err1),
    .o_mem_en       (mem_en),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .i_mem_rdata    (mem_rdata),
    .o_conflict_cnt (conflict_cnt)
  );

  // Synchronous memory: read data one cycle after the command.
  always @(posedge tb_i_clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= {24'hA5A5A5, 8'(i)};
      mem[1] <= 32'hDEADBEEF;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  initial begin
    rst = 1'b1;
    set0(1'b0, 1'b0, 8'h00, 32'h0);
    set1(1'b0, 1'b0, 8'h00, 32'h0);
    mem_rdata = 32'h0;
    repeat (2) @(negedge tb_i_clk);

    // Reset state, with a write request held during reset
    set0(1'b1, 1'b1, 8'h00, 32'h11111111);
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_cnt", 32'(conflict_cnt), 32'd0);

    // Three-cycle read conflict: grants 0,1,0
    @(negedge tb_i_clk);
    rst = 1'b0;
    set0(1'b1, 1'b0, 8'h00, 32'h0);
    set1(1'b1, 1'b0, 8'h08, 32'h0);
    #1;
    chk("c1_gnt0", 32'(gnt0), 32'd1);
    chk("c1_gnt1", 32'(gnt1), 32'd0);
    @(negedge tb_i_clk); #1;
    chk("c2_gnt0", 32'(gnt0), 32'd0);
    chk("c2_gnt1", 32'(gnt1), 32'd1);
    chk("c2_rvalid0", 32'(rvalid0), 32'd1);
    chk("c2_rdata0", rdata0, 32'hA5A5A500);
    chk("c2_rvalid1", 32'(rvalid1), 32'd0);
    @(negedge tb_i_clk); #1;
    chk("c3_gnt0", 32'(gnt0), 32'd1);
    chk("c3_gnt1", 32'(gnt1), 32'd0);
    chk("c3_rvalid1", 32'(rvalid1), 32'd1);
    chk("c3_rdata1", rdata1, 32'hA5A5A502);

    // Port 0 alone reads 0x04
    @(negedge tb_i_clk);
    set1(1'b0, 1'b0, 8'h00, 32'h0);
    set0(1'b1, 1'b0, 8'h04, 32'h0);
    #1;
    chk("conflict_cnt3", 32'(conflict_cnt), 32'd3);
    chk("c3_resp_rvalid0", 32'(rvalid0), 32'd1);
    chk("c3_resp_rdata0", rdata0, 32'hA5A5A500);
    chk("r04_gnt0", 32'(gnt0), 32'd1);
    chk("r04_mem_en", 32'(mem_en), 32'd1);
    chk("r04_mem_addr", 32'(mem_addr), 32'h04);
    @(negedge tb_i_clk);
    set0(1'b0, 1'b0, 8'h00, 32'h0);
    #1;
    chk("r04_rvalid0", 32'(rvalid0), 32'd1);
    chk("r04_rdata0", rdata0, 32'hDEADBEEF);
    chk("r04_rvalid1", 32'(rvalid1), 32'd0);

    // Port 1 write 0x12345678 @0x10, then port 0 reads it back
    @(negedge tb_i_clk);
    set1(1'b1, 1'b1, 8'h10, 32'h12345678);
    #1;
    chk("idle_rvalid0", 32'(rvalid0), 32'd0);
    chk("hold_rdata0", rdata0, 32'hDEADBEEF);
    chk("w10_gnt1", 32'(gnt1), 32'd1);
    chk("w10_mem_we", 32'(mem_we), 32'd1);
    chk("w10_mem_addr", 32'(mem_addr), 32'h10);
    chk("w10_mem_wdata", mem_wdata, 32'h12345678);
    @(negedge tb_i_clk);
    set1(1'b0, 1'b0, 8'h00, 32'h0);
    set0(1'b1, 1'b0, 8'h10, 32'h0);
    #1;
    chk("r10_gnt0", 32'(gnt0), 32'd1);
    chk("w10_no_rvalid1", 32'(rvalid1), 32'd0);
    chk("w10_no_err1", 32'(err1), 32'd0);

    // Misaligned write @0x06 right behind the read
    @(negedge tb_i_clk);
    set0(1'b1, 1'b1, 8'h06, 32'hCAFEF00D);
    #1;
    chk("r10_rvalid0", 32'(rvalid0), 32'd1);
    chk("r10_rdata0", rdata0, 32'h12345678);
    chk("w06_gnt0", 32'(gnt0), 32'd1);
    chk("w06_mem_en", 32'(mem_en), 32'd0);
    chk("w06_mem_we", 32'(mem_we), 32'd0);
    @(negedge tb_i_clk);
    set0(1'b1, 1'b0, 8'h04, 32'h0);
    #1;
    chk("w06_err0", 32'(err0), 32'd1);
    chk("w06_rvalid0", 32'(rvalid0), 32'd0);
    @(negedge tb_i_clk);
    set0(1'b0, 1'b0, 8'h00, 32'h0);
    #1;
    chk("err0_one_cycle", 32'(err0), 32'd0);
    chk("w06_mem_kept_rvalid", 32'(rvalid0), 32'd1);
    chk("w06_mem_kept", rdata0, 32'hDEADBEEF);

    // Read granted, then reset: response dropped, port 0 wins next conflict
    @(negedge tb_i_clk);
    set0(1'b1, 1'b0, 8'h08, 32'h0);
    #1;
    chk("pre_rst_gnt0", 32'(gnt0), 32'd1);
    @(negedge tb_i_clk);
    rst = 1'b1;
    set0(1'b0, 1'b0, 8'h00, 32'h0);
    #1;
    chk("rst_drop_rvalid0", 32'(rvalid0), 32'd0);
    @(negedge tb_i_clk); #1;
    chk("rst_after_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_after_rdata0", rdata0, 32'h0);
    chk("rst_after_cnt", 32'(conflict_cnt), 32'd0);
    @(negedge tb_i_clk);
    rst = 1'b0;
    set0(1'b1, 1'b0, 8'h00, 32'h0);
    set1(1'b1, 1'b0, 8'h08, 32'h0);
    #1;
    chk("post_rst_gnt0", 32'(gnt0), 32'd1);
    chk("post_rst_gnt1", 32'(gnt1), 32'd0);

    // Counter saturation from 16'hFFFE under a held conflict
    @(negedge tb_i_clk);
    force dut.conflict_cnt_q = 16'hFFFE;
    #1;
    release dut.conflict_cnt_q;
    @(negedge tb_i_clk); #1;
    chk("sat_cnt1", 32'(conflict_cnt), 32'hFFFF);
    @(negedge tb_i_clk);
    @(negedge tb_i_clk); #1;
    chk("sat_cnt3", 32'(conflict_cnt), 32'hFFFF);

    set0(1'b0, 1'b0, 8'h00, 32'h0);
    set1(1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge tb_i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
